front_panel_loader: RTL
=======================

Name: front_panel_loader

Overview:
- Board-side writer that moves user-entered 16-bit words from the slide switches into processor instruction memory.
- Inputs are debounced single-cycle key strobes (KeyFilter Strobe outputs) plus switch values.
- Latches a word, issues a req/ack write to the memory port, then auto-increments a 7-bit address matching the PC width.
- Sits in the board top level between the KeyFilter instances and the processor's memory write port.

Parameters:
WIDTH, 16, data word width
ADDR_W, 7, memory address width (matches PC width)
TIMEOUT, 255, max cycles WrReq is held waiting for WrAck before abort (must be >= 1)

Ports:
Clock  input  1  system clock, all state changes on rising edge
Reset_n  input  1  asynchronous, active-low reset
LoadStrobe  input  1  one-cycle pulse: write Switches at the current address
AddrStrobe  input  1  one-cycle pulse: set the address from Switches[ADDR_W-1:0] and clear flags
Switches  input  WIDTH  user data/address source
WrReq  output  1  write request to memory, level, registered
WrAddr  output  ADDR_W  write address, stable while WrReq=1
WrData  output  WIDTH  write data, stable while WrReq=1
WrAck  input  1  memory accepts write; sampled only while WrReq=1
Busy  output  1  1 while in REQ state
Addr  output  ADDR_W  current (next-to-write) address, for hex display
WordCount  output  8  successful writes since last AddrStrobe, saturates at 255
Timeout  output  1  sticky: a write was aborted for lack of WrAck
Overrun  output  1  sticky: a strobe arrived while Busy, or both strobes arrived together

Behaviour:
Reset (async, Reset_n=0):
- State=IDLE; WrReq=0, WrAddr=0, WrData=0, Addr=0, WordCount=0.
- Timeout=0, Overrun=0, wait counter=0.
- Outputs take these values immediately, without waiting for a Clock edge.
- Reset asserted mid-write drops WrReq at once. The in-flight write is discarded and is not counted.

State machine, two states, IDLE and REQ. All outputs are registered.

IDLE, AddrStrobe=1:
- Addr <= Switches[ADDR_W-1:0]; WordCount <= 0; Timeout <= 0; Overrun <= 0.
- If LoadStrobe=1 in the same cycle: LoadStrobe is dropped and Overrun <= 1. This Overrun set overrides the clear.

IDLE, LoadStrobe=1 and AddrStrobe=0:
- WrData <= Switches; WrAddr <= Addr; WrReq <= 1; wait counter <= 0; go to REQ.
- WrReq is visible the cycle after the strobe edge.

REQ:
- Busy=1. WrReq, WrAddr and WrData are held constant.
- Any LoadStrobe or AddrStrobe is ignored and sets Overrun <= 1.

REQ, edge with WrAck=1:
- WrReq <= 0; Addr <= Addr+1, wrapping 2^ADDR_W-1 -> 0; WordCount <= min(WordCount+1, 255); go to IDLE.
- Ack on the first REQ cycle is legal, giving a minimum write of one cycle of WrReq.

REQ, edge with WrAck=0:
- Wait counter increments.
- When the counter reaches TIMEOUT-1 with WrAck still 0: WrReq <= 0, Timeout <= 1, Addr and WordCount unchanged, go to IDLE.
- WrAck=1 on that same edge takes priority over the timeout, and the write succeeds.

Other rules:
- WrAck while in IDLE is ignored.
- Busy is a combinational decode of the state register.
- WrAddr and WrData keep their last values in IDLE.
- Bits of Switches above ADDR_W are ignored for AddrStrobe.

Test Plan:
- Reset, AddrStrobe with Switches=16'h0005, LoadStrobe with Switches=16'hBEEF, WrAck one cycle after WrReq rises -> WrAddr=5, WrData=BEEF while WrReq=1; afterwards Addr=6, WordCount=1, WrReq=0, flags 0.
- AddrStrobe with Switches=16'h007F, then two loads (16'h1111, 16'h2222), each acked immediately -> writes land at 7F then 00 (wrap); Addr=01; WordCount=2.
- LoadStrobe, WrAck held 0, TIMEOUT=4 -> WrReq high exactly 4 cycles then low; Timeout=1; Addr unchanged; WordCount unchanged. A following AddrStrobe clears Timeout.
- LoadStrobe, then a second LoadStrobe and an AddrStrobe while Busy, ack after 3 cycles -> exactly one write, WrAddr/WrData unchanged throughout, Overrun=1, Addr incremented once.
- LoadStrobe and AddrStrobe in the same IDLE cycle with Switches=16'h0010 -> no WrReq, Addr=10, Overrun=1, WordCount=0.
- Reset_n pulled low asynchronously while WrReq=1 (between Clock edges) -> WrReq=0, Addr=0, WordCount=0 without waiting for a Clock edge; a late WrAck after release has no effect.

Source files
------------

// File: rtl/front_panel_loader.sv
// Front-panel word loader: copies switch values into instruction memory
// through a req/ack write port, auto-incrementing the target address.
module front_panel_loader #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 255
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              LoadStrobe,
  input  logic              AddrStrobe,
  input  logic [WIDTH-1:0]  Switches,
  output logic              WrReq,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [WIDTH-1:0]  WrData,
  input  logic              WrAck,
  output logic              Busy,
  output logic [ADDR_W-1:0] Addr,
  output logic [7:0]        WordCount,
  output logic              Timeout,
  output logic              Overrun
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          count_q, count_d;
  logic                to_q, to_d;
  logic                ovr_q, ovr_d;
  logic [CNT_W-1:0]    wait_q, wait_d;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    count_d   = count_q;
    to_d      = to_q;
    ovr_d     = ovr_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: begin
        if (AddrStrobe) begin
          addr_d  = Switches[ADDR_W-1:0];
          count_d = '0;
          to_d    = 1'b0;
          // a simultaneous load is dropped and flagged
          ovr_d   = LoadStrobe;
        end else if (LoadStrobe) begin
          wr_data_d = Switches;
          wr_addr_d = addr_q;
          wait_d    = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (LoadStrobe || AddrStrobe)
          ovr_d = 1'b1;
        if (WrAck) begin
          state_d = IDLE;
          addr_d  = addr_q + ADDR_W'(1);
          if (count_q != 8'hFF)
            count_d = count_q + 8'd1;
        end else if (wait_q == CNT_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      to_q      <= 1'b0;
      ovr_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      to_q      <= to_d;
      ovr_q     <= ovr_d;
      wait_q    <= wait_d;
    end
  end

  assign Busy      = (state_q == REQ);
  assign WrReq     = req_q;
  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  assign Addr      = addr_q;
  assign WordCount = count_q;
  assign Timeout   = to_q;
  assign Overrun   = ovr_q;

endmodule
